// File: rtl/mc_maindec_pkg.sv
// Shared constants, state encoding and per-state control decode for the
// multicycle main control FSM.
package mc_maindec_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [2:0] OP_IMM_HI = 3'b001;      // ADDI..LUI share op[5:3]
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JUMPR  = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_R_TYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
               (op[5:3] == OP_IMM_HI);
    endfunction

    function automatic state_e decode_next(input logic [5:0] op,
                                           input logic [5:0] funct,
                                           input logic       en_jr);
        state_e s;
        s = S_FETCH;
        if (op == OP_R_TYPE)
            s = (en_jr && funct == FUNCT_JR) ? S_JUMPR : S_EXEC;
        else if (op == OP_LW || op == OP_SW)
            s = S_MEMADR;
        else if (op == OP_BEQ || op == OP_BNE)
            s = S_BRANCH;
        else if (op == OP_J)
            s = S_JUMP;
        else if (op[5:3] == OP_IMM_HI)
            s = S_IMMEX;
        return s;
    endfunction

    // Moore strobes only; mem_ready-qualified and op-qualified ones live in the top.
    function automatic ctrl_t state_ctrl(input state_e s, input logic bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_ALU;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_IMMEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_IMM;
            end
            S_IMMWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_RT;
                c.alu_op     = ALU_SUB;
                c.branch     = 1'b1;
                c.branch_ne  = bne;
                c.pc_src     = PC_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_src     = PC_JUMP;
                c.instr_done = 1'b1;
            end
            S_JUMPR: begin
                c.pc_write   = 1'b1;
                c.pc_src     = PC_RS;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// Control bundle between the instruction register / memory and the
// multicycle datapath; master is the main decoder.
interface mc_maindec_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
    logic [3:0] state_o;

    modport master (
        input  op, funct, mem_ready,
        output pc_write, branch, branch_ne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, pc_src, instr_done, illegal, mem_err,
               state_o
    );

    modport slave (
        output op, funct, mem_ready,
        input  pc_write, branch, branch_ne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, pc_src, instr_done, illegal, mem_err,
               state_o
    );

endinterface

// File: rtl/mc_mem_timer.sv
// Memory wait-state counter: clears on request, counts stalled cycles,
// saturates, and flags a timeout at the threshold while still stalled.
module mc_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int unsigned CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != '1)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign timeout = (MEM_TIMEOUT != 0) && en && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the datapath strobes, with a timed memory handshake.
import mc_maindec_pkg::*;

module mc_maindec #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          EN_JR       = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    mc_maindec_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   store_q, store_d;
    logic   bne_q, bne_d;

    logic   in_wait, tmr_en, tmr_clr, timeout;
    logic   fetch_done, dec_illegal;

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign tmr_en  = in_wait && !bus.mem_ready;

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        bne_d   = bne_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d = decode_next(bus.op, bus.funct, EN_JR);
                store_d = (bus.op == OP_SW);
                bne_d   = (bus.op == OP_BNE);
            end
            S_MEMADR: state_d = store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready)
                    state_d = S_MEMWB;
                else if (timeout)
                    state_d = S_FETCH;
            end
            S_MEMWR:  if (bus.mem_ready || timeout) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
        // Moore strobes are registered against the state being entered.
        ctrl_d = state_ctrl(state_d, bne_d);
    end

    // A timed-out FETCH re-enters itself, so the retry must also clear the count.
    assign tmr_clr = ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR)) &&
                     ((state_d != state_q) || timeout);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            store_q <= 1'b0;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            store_q <= store_d;
            bne_q   <= bne_d;
        end
    end

    mc_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .timeout (timeout)
    );

    assign fetch_done  = (state_q == S_FETCH) && bus.mem_ready;
    assign dec_illegal = (state_q == S_DECODE) && !op_is_legal(bus.op);

    assign bus.pc_write   = ctrl_q.pc_write | fetch_done;
    assign bus.ir_write   = fetch_done;
    assign bus.branch     = ctrl_q.branch;
    assign bus.branch_ne  = ctrl_q.branch_ne;
    assign bus.iord       = ctrl_q.iord;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.pc_src     = ctrl_q.pc_src;
    assign bus.instr_done = ctrl_q.instr_done | dec_illegal |
                            ((state_q == S_MEMWR) && bus.mem_ready) |
                            (timeout && (state_q != S_FETCH));
    assign bus.illegal    = dec_illegal;
    assign bus.mem_err    = timeout;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboarded bench for mc_maindec: an instruction-level model expands each
// instruction into expected per-cycle strobe vectors, checked by a monitor.
module tb_mc_maindec;

    localparam int unsigned T = 3;

    typedef struct packed {
        logic        rst_n;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        mr;
        logic [20:0] exp;
    } row_t;

    row_t        plan[$];
    logic [20:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rowno  = 0;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mc_maindec_if bus();

    mc_maindec #(
        .MEM_TIMEOUT(T),
        .EN_JR      (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // {idle, pc_write, branch, branch_ne, iord, mem_read, mem_write, ir_write,
    //  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
    //  instr_done, illegal, mem_err}
    function automatic logic [20:0] v(input bit idle, pcw, br, brne, iord, mrd, mwr, irw,
                                      input bit rw, rdst, m2r, asa,
                                      input logic [1:0] asb, aop, psrc,
                                      input bit done, ill, merr);
        return {idle, pcw, br, brne, iord, mrd, mwr, irw, rw, rdst, m2r, asa,
                asb, aop, psrc, done, ill, merr};
    endfunction

    function automatic logic [20:0] ph_idle();
        return v(1, 0,0,0,0,0,0,0, 0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0);
    endfunction
    function automatic logic [20:0] ph_fetch(input bit rdy, input bit merr);
        return v(0, rdy,0,0,0,1,0,rdy, 0,0,0,0, 2'b01,2'b00,2'b00, 0,0,merr);
    endfunction
    function automatic logic [20:0] ph_decode(input bit ill);
        return v(0, 0,0,0,0,0,0,0, 0,0,0,0, 2'b11,2'b00,2'b00, ill,ill,0);
    endfunction
    function automatic logic [20:0] ph_memadr();
        return v(0, 0,0,0,0,0,0,0, 0,0,0,1, 2'b10,2'b00,2'b00, 0,0,0);
    endfunction
    function automatic logic [20:0] ph_mem(input bit wr, input bit done, input bit merr);
        return v(0, 0,0,0,1,!wr,wr,0, 0,0,0,0, 2'b00,2'b00,2'b00, done,0,merr);
    endfunction
    function automatic logic [20:0] ph_memwb();
        return v(0, 0,0,0,0,0,0,0, 1,0,1,0, 2'b00,2'b00,2'b00, 1,0,0);
    endfunction
    function automatic logic [20:0] ph_exec();
        return v(0, 0,0,0,0,0,0,0, 0,0,0,1, 2'b00,2'b10,2'b00, 0,0,0);
    endfunction
    function automatic logic [20:0] ph_aluwb();
        return v(0, 0,0,0,0,0,0,0, 1,1,0,0, 2'b00,2'b00,2'b00, 1,0,0);
    endfunction
    function automatic logic [20:0] ph_immex();
        return v(0, 0,0,0,0,0,0,0, 0,0,0,1, 2'b10,2'b11,2'b00, 0,0,0);
    endfunction
    function automatic logic [20:0] ph_immwb();
        return v(0, 0,0,0,0,0,0,0, 1,0,0,0, 2'b00,2'b00,2'b00, 1,0,0);
    endfunction
    function automatic logic [20:0] ph_branch(input bit ne);
        return v(0, 0,1,ne,0,0,0,0, 0,0,0,1, 2'b00,2'b01,2'b01, 1,0,0);
    endfunction
    function automatic logic [20:0] ph_jump(input bit reg_target);
        return v(0, 1,0,0,0,0,0,0, 0,0,0,0, 2'b00,2'b00, reg_target ? 2'b11 : 2'b10, 1,0,0);
    endfunction

    task automatic add(input bit rst_n, input logic [5:0] op, input logic [5:0] funct,
                       input bit mr, input logic [20:0] exp);
        row_t r;
        r.rst_n = rst_n; r.op = op; r.funct = funct; r.mr = mr; r.exp = exp;
        plan.push_back(r);
    endtask

    // Row whose op/funct/mem_ready are noise: the DUT must ignore them.
    task automatic add_any(input logic [20:0] exp);
        add(1, 6'($urandom), 6'($urandom), 1'($urandom), exp);
    endtask

    // d = stalled cycles before mem_ready; every T+1 stalled cycles the fetch retries.
    task automatic fetch(input int d);
        int rem = d;
        int i = 0;
        while (1) begin
            if (rem == 0) begin
                add(1, 6'($urandom), 6'($urandom), 1, ph_fetch(1, 0));
                return;
            end else if (i == int'(T)) begin
                add(1, 6'($urandom), 6'($urandom), 0, ph_fetch(0, 1));
                rem--; i = 0;
            end else begin
                add(1, 6'($urandom), 6'($urandom), 0, ph_fetch(0, 0));
                rem--; i++;
            end
        end
    endtask

    task automatic mem_wait(input bit wr, input int d, output bit timed_out);
        int rem = d;
        int i = 0;
        timed_out = 0;
        while (1) begin
            if (rem == 0) begin
                add(1, 6'($urandom), 6'($urandom), 1, ph_mem(wr, wr, 0));
                return;
            end else if (i == int'(T)) begin
                add(1, 6'($urandom), 6'($urandom), 0, ph_mem(wr, 1, 1));
                timed_out = 1;
                return;
            end else begin
                add(1, 6'($urandom), 6'($urandom), 0, ph_mem(wr, 0, 0));
                rem--; i++;
            end
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] funct, input int df, input int dm);
        bit legal, to;
        legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
                (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000010) ||
                (op >= 6'b001000 && op <= 6'b001111);
        fetch(df);
        add(1, op, funct, 1'($urandom), ph_decode(!legal));
        if (!legal) return;
        if (op == 6'b000000) begin
            if (funct == 6'b001000) add_any(ph_jump(1));
            else begin add_any(ph_exec()); add_any(ph_aluwb()); end
        end else if (op == 6'b100011) begin
            add_any(ph_memadr());
            mem_wait(0, dm, to);
            if (!to) add_any(ph_memwb());
        end else if (op == 6'b101011) begin
            add_any(ph_memadr());
            mem_wait(1, dm, to);
        end else if (op == 6'b000100 || op == 6'b000101) begin
            add_any(ph_branch(op == 6'b000101));
        end else if (op == 6'b000010) begin
            add_any(ph_jump(0));
        end else begin
            add_any(ph_immex()); add_any(ph_immwb());
        end
    endtask

    task automatic reset_rows();
        add(0, 6'($urandom), 6'($urandom), 1'($urandom), ph_idle());
        add(0, 6'($urandom), 6'($urandom), 1'($urandom), ph_idle());
        add(1, 6'($urandom), 6'($urandom), 1, ph_idle());
    endtask

    always @(negedge clk) begin
        logic [20:0] act, e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act = {bus.state_o == 4'd0, bus.pc_write, bus.branch, bus.branch_ne, bus.iord,
                   bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst,
                   bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                   bus.instr_done, bus.illegal, bus.mem_err};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL strobes row %0d (state_o=%0d): got %b required %b",
                         rowno, bus.state_o, act, e);
            end
            rowno++;
        end
    end

    initial begin
        row_t r;
        int sel;
        bus.op = '0; bus.funct = '0; bus.mem_ready = 1'b0;

        reset_rows();
        // Abort an LW while it waits in MEMRD.
        fetch(0);
        add(1, 6'b100011, 6'($urandom), 1'($urandom), ph_decode(0));
        add_any(ph_memadr());
        add(1, 6'($urandom), 6'($urandom), 0, ph_mem(0, 0, 0));
        reset_rows();

        instr(6'b000000, 6'b100000, 0, 0);
        instr(6'b001000, 6'($urandom), 0, 0);
        instr(6'b100011, 6'($urandom), 0, 0);
        instr(6'b101011, 6'($urandom), 0, 0);
        instr(6'b000100, 6'($urandom), 0, 0);
        instr(6'b000010, 6'($urandom), 0, 0);
        instr(6'b000101, 6'($urandom), 0, 0);
        instr(6'b111111, 6'($urandom), 0, 0);
        instr(6'b101011, 6'($urandom), 0, 10);
        instr(6'b000000, 6'b001000, 3, 0);
        instr(6'b100011, 6'($urandom), 5, 3);
        instr(6'b100011, 6'($urandom), 0, 4);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op, fn;
            int df, dm;
            sel = $urandom_range(0, 7);
            fn  = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            case (sel)
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000101;
                5: op = 6'b000010;
                6: op = 6'b001000 | 6'($urandom_range(0, 7));
                default: op = 6'($urandom);
            endcase
            df = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : 0;
            dm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : 0;
            instr(op, fn, df, dm);
        end

        while (plan.size() != 0) begin
            r = plan.pop_front();
            @(posedge clk);
            #1;
            resetn        = r.rst_n;
            bus.op        = r.op;
            bus.funct     = r.funct;
            bus.mem_ready = r.mr;
            exp_q.push_back(r.exp);
        end

        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
